// File: rtl/sw_stripe_engine_pkg.sv
// Shared types for the Smith-Waterman stripe engine: source codes, FSM states, packet sizing.
// Traceback logic is built only when SW_TRACEBACK_EN is defined.
package design_variables;

  localparam int SOURCE_WIDTH     = 2;
  localparam int DATA_PACKET_SIZE = SOURCE_WIDTH + 1;  // {zero_bit, source}
  localparam int SCORE_WIDTH_DEF  = 10;

  // Default-width score; parameterised modules size their own score vectors.
  typedef logic [SCORE_WIDTH_DEF-1:0] score_t;

  typedef enum logic [SOURCE_WIDTH-1:0] {
    SRC_NONE = 2'd0,
    SRC_DIAG = 2'd1,
    SRC_TOP  = 2'd2,
    SRC_LEFT = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sw_stripe_engine_cell.sv
// One combinational Smith-Waterman cell: H = max(0, diag+sub, top+GAP, left+GAP), saturated.
// Source/zero outputs exist only when SW_TRACEBACK_EN is defined.
module sw_cell
  import design_variables::*;
#(
  parameter int LETTER_WIDTH = 2,
  parameter int SCORE_WIDTH  = 10,
  parameter int MATCH        = 2,
  parameter int MISMATCH     = -1,
  parameter int GAP          = -1
) (
  input  logic [LETTER_WIDTH-1:0] q_letter,
  input  logic [LETTER_WIDTH-1:0] db_letter,
  input  logic [SCORE_WIDTH-1:0]  h_diag,
  input  logic [SCORE_WIDTH-1:0]  h_top,
  input  logic [SCORE_WIDTH-1:0]  h_left,
  output logic [SCORE_WIDTH-1:0]  h
`ifdef SW_TRACEBACK_EN
  ,
  output src_e                    src,
  output logic                    zero
`endif
);

  // Two guard bits cover both the negative candidates and the +MATCH overshoot.
  localparam int EW = SCORE_WIDTH + 2;
  localparam logic signed [EW-1:0] SAT = EW'((1 << SCORE_WIDTH) - 1);

  logic signed [EW-1:0] sub, c_diag, c_top, c_left, best;
  src_e                 sel;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sub    = (q_letter == db_letter) ? EW'(MATCH) : EW'(MISMATCH);
    c_diag = $signed({2'b00, h_diag}) + sub;
    c_top  = $signed({2'b00, h_top}) + EW'(GAP);
    c_left = $signed({2'b00, h_left}) + EW'(GAP);

    sel = SRC_LEFT;
    if (c_diag >= c_top && c_diag >= c_left) sel = SRC_DIAG;
    else if (c_top >= c_left)                sel = SRC_TOP;

    best = c_left;
    case (sel)
      SRC_DIAG: best = c_diag;
      SRC_TOP:  best = c_top;
      default:  best = c_left;
    endcase

    h = best[SCORE_WIDTH-1:0];
    if (best <= 0)       h = '0;
    else if (best > SAT) h = '1;
  end

`ifdef SW_TRACEBACK_EN
  assign zero = (best <= 0);
  assign src  = (best <= 0) ? SRC_NONE : sel;
`endif

endmodule

// File: rtl/sw_stripe_engine.sv
// Self-sequencing Smith-Waterman stripe engine: one NUM_PE-row column per cycle, db replayed
// from an internal buffer after stripe 0. Traceback packets are driven only with SW_TRACEBACK_EN.
module sw_stripe_engine
  import design_variables::*;
#(
  parameter int LETTER_WIDTH = 2,
  parameter int SCORE_WIDTH  = 10,
  parameter int NUM_PE       = 4,
  parameter int QUERY_LEN    = 16,
  parameter int DB_LEN_MAX   = 64,
  parameter int MATCH        = 2,
  parameter int MISMATCH     = -1,
  parameter int GAP          = -1,
  localparam int DB_W        = $clog2(DB_LEN_MAX + 1),
  localparam int NUM_STRIPES = QUERY_LEN / NUM_PE,
  localparam int STRIPE_W    = (NUM_STRIPES > 1) ? $clog2(NUM_STRIPES) : 1,
  localparam int ROW_W       = $clog2(QUERY_LEN)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [QUERY_LEN*LETTER_WIDTH-1:0]    query_seq,
  input  logic [DB_W-1:0]                      db_len,
  input  logic                                 db_valid,
  output logic                                 db_ready,
  input  logic [LETTER_WIDTH-1:0]              db_letter,
  output logic                                 packet_valid,
  output logic [STRIPE_W-1:0]                  packet_stripe,
  output logic [DB_W-1:0]                      packet_col,
  output logic [NUM_PE*DATA_PACKET_SIZE-1:0]   packet_data,
  output logic                                 busy,
  output logic                                 done,
  output logic [SCORE_WIDTH-1:0]               max_score,
  output logic [ROW_W-1:0]                     max_row,
  output logic [DB_W-1:0]                      max_col
);

  localparam int ADDR_W = (DB_LEN_MAX > 1) ? $clog2(DB_LEN_MAX) : 1;
  localparam logic [STRIPE_W-1:0] LAST_STRIPE = STRIPE_W'(NUM_STRIPES - 1);

  state_e state_q, state_d;

  logic [DB_W-1:0]                   col_q, len_q, len_clamped;
  logic [STRIPE_W-1:0]               stripe_q;
  logic [QUERY_LEN*LETTER_WIDTH-1:0] query_q;
  logic [SCORE_WIDTH-1:0]            left_q [NUM_PE];
  logic [SCORE_WIDTH-1:0]            top_diag_q;

  logic [SCORE_WIDTH-1:0]  bnd_mem [DB_LEN_MAX];
  logic [LETTER_WIDTH-1:0] let_mem [DB_LEN_MAX];

  logic                    accept, compute, col_last, stripe_last;
  logic [ADDR_W-1:0]       addr;
  logic [LETTER_WIDTH-1:0] cur_letter;
  logic [SCORE_WIDTH-1:0]  top_in;

  logic [SCORE_WIDTH-1:0]  h      [NUM_PE];
  logic [SCORE_WIDTH-1:0]  diag_c [NUM_PE];
  logic [SCORE_WIDTH-1:0]  top_c  [NUM_PE];
  logic [LETTER_WIDTH-1:0] q_let  [NUM_PE];

  logic [SCORE_WIDTH-1:0]  best_score;
  logic [ROW_W-1:0]        best_row;
  logic [DB_W-1:0]         best_col;

  assign accept      = (state_q == IDLE) && start;
  assign compute     = ((state_q == LOAD) && db_valid) || (state_q == RUN);
  assign col_last    = (col_q == (len_q - DB_W'(1)));
  assign stripe_last = (stripe_q == LAST_STRIPE);
  assign addr        = col_q[ADDR_W-1:0];
  assign len_clamped = (db_len > DB_W'(DB_LEN_MAX)) ? DB_W'(DB_LEN_MAX) : db_len;

  // Stripe 0 sees a zero top boundary; the buffer is unreset and only trusted afterwards.
  assign cur_letter = (state_q == LOAD) ? db_letter : let_mem[addr];
  assign top_in     = (stripe_q == '0) ? '0 : bnd_mem[addr];

  assign db_ready = (state_q == LOAD);
  assign busy     = (state_q == LOAD) || (state_q == RUN);
  assign done     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (db_len == '0) ? DONE : LOAD;
      LOAD: if (db_valid && col_last) state_d = (NUM_STRIPES > 1) ? RUN : DONE;
      RUN:  if (col_last && stripe_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef SW_TRACEBACK_EN
  src_e src_v  [NUM_PE];
  logic zero_v [NUM_PE];
`endif

  for (genvar r = 0; r < NUM_PE; r++) begin : g_pe
    assign q_let[r] = query_q[(int'(stripe_q) * NUM_PE + r) * LETTER_WIDTH +: LETTER_WIDTH];
    if (r == 0) begin : g_top
      assign diag_c[r] = top_diag_q;
      assign top_c[r]  = top_in;
    end else begin : g_inner
      assign diag_c[r] = left_q[r-1];
      assign top_c[r]  = h[r-1];
    end

    sw_cell #(
      .LETTER_WIDTH (LETTER_WIDTH),
      .SCORE_WIDTH  (SCORE_WIDTH),
      .MATCH        (MATCH),
      .MISMATCH     (MISMATCH),
      .GAP          (GAP)
    ) u_cell (
      .q_letter  (q_let[r]),
      .db_letter (cur_letter),
      .h_diag    (diag_c[r]),
      .h_top     (top_c[r]),
      .h_left    (left_q[r]),
      .h         (h[r])
`ifdef SW_TRACEBACK_EN
      ,
      .src       (src_v[r]),
      .zero      (zero_v[r])
`endif
    );
  end

  // Strictly-greater scan from row 0 keeps the earliest position on ties.
  always_comb begin
    best_score = max_score;
    best_row   = max_row;
    best_col   = max_col;
    for (int r = 0; r < NUM_PE; r++) begin
      if (h[r] > best_score) begin
        best_score = h[r];
        best_row   = ROW_W'(int'(stripe_q) * NUM_PE + r);
        best_col   = col_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      stripe_q   <= '0;
      len_q      <= '0;
      query_q    <= '0;
      top_diag_q <= '0;
      max_score  <= '0;
      max_row    <= '0;
      max_col    <= '0;
      for (int r = 0; r < NUM_PE; r++) left_q[r] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        col_q      <= '0;
        stripe_q   <= '0;
        len_q      <= len_clamped;
        query_q    <= query_seq;
        top_diag_q <= '0;
        max_score  <= '0;
        max_row    <= '0;
        max_col    <= '0;
        for (int r = 0; r < NUM_PE; r++) left_q[r] <= '0;
      end else if (compute) begin
        max_score <= best_score;
        max_row   <= best_row;
        max_col   <= best_col;
        if (col_last) begin
          col_q      <= '0;
          stripe_q   <= stripe_q + 1'b1;
          top_diag_q <= '0;
          for (int r = 0; r < NUM_PE; r++) left_q[r] <= '0;
        end else begin
          col_q      <= col_q + 1'b1;
          top_diag_q <= top_in;
          for (int r = 0; r < NUM_PE; r++) left_q[r] <= h[r];
        end
      end
    end
  end

  // NOTE: the buffers are plain RAM with no reset; reads are gated so stale data is never used.
  always_ff @(posedge clk) begin
    if ((state_q == LOAD) && db_valid) let_mem[addr] <= db_letter;
    if (compute) bnd_mem[addr] <= h[NUM_PE-1];
  end

`ifdef SW_TRACEBACK_EN
  logic [NUM_PE*DATA_PACKET_SIZE-1:0] pkt_d;

  always_comb begin
    pkt_d = '0;
    for (int r = 0; r < NUM_PE; r++)
      pkt_d[r*DATA_PACKET_SIZE +: DATA_PACKET_SIZE] = {zero_v[r], src_v[r]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      packet_valid  <= 1'b0;
      packet_stripe <= '0;
      packet_col    <= '0;
      packet_data   <= '0;
    end else begin
      packet_valid <= compute;
      if (compute) begin
        packet_stripe <= stripe_q;
        packet_col    <= col_q;
        packet_data   <= pkt_d;
      end
    end
  end
`else
  assign packet_valid  = 1'b0;
  assign packet_stripe = '0;
  assign packet_col    = '0;
  assign packet_data   = '0;
`endif

endmodule

// File: tb/tb_sw_stripe_engine.sv
// Self-checking bench for sw_stripe_engine against a full-matrix Smith-Waterman model.
// Packet contents are checked when SW_TRACEBACK_EN is defined, else packets must stay idle.
module tb_sw_stripe_engine;

  localparam int QL = 8;
  localparam int DBMAX = 16;
  localparam int DBW = 5;
`ifdef SW_TRACEBACK_EN
  localparam bit TB_TRACE = 1'b1;
`else
  localparam bit TB_TRACE = 1'b0;
`endif

  typedef struct {
    int         stripe;
    int         col;
    logic [11:0] data;
  } pkt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [15:0] query_seq = '0;
  logic [DBW-1:0] db_len = '0;
  logic        db_valid = 1'b0;
  logic        db_ready;
  logic [1:0]  db_letter = '0;
  logic        packet_valid;
  logic        packet_stripe;
  logic [DBW-1:0] packet_col;
  logic [11:0] packet_data;
  logic        busy, done;
  logic [9:0]  max_score;
  logic [2:0]  max_row;
  logic [DBW-1:0] max_col;

  sw_stripe_engine #(
    .LETTER_WIDTH(2), .SCORE_WIDTH(10), .NUM_PE(4), .QUERY_LEN(QL),
    .DB_LEN_MAX(DBMAX), .MATCH(2), .MISMATCH(-1), .GAP(-1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .query_seq(query_seq), .db_len(db_len),
    .db_valid(db_valid), .db_ready(db_ready), .db_letter(db_letter),
    .packet_valid(packet_valid), .packet_stripe(packet_stripe), .packet_col(packet_col),
    .packet_data(packet_data), .busy(busy), .done(done),
    .max_score(max_score), .max_row(max_row), .max_col(max_col)
  );

  // Narrow-score instance for the saturation scenario.
  logic        s_start = 1'b0;
  logic [15:0] s_query = '0;
  logic [3:0]  s_len = '0;
  logic        s_db_valid = 1'b0;
  logic        s_db_ready;
  logic [1:0]  s_letter = '0;
  logic        s_pv;
  logic        s_ps;
  logic [3:0]  s_pc;
  logic [11:0] s_pd;
  logic        s_busy, s_done;
  logic [3:0]  s_max;
  logic [2:0]  s_row;
  logic [3:0]  s_col;

  sw_stripe_engine #(
    .LETTER_WIDTH(2), .SCORE_WIDTH(4), .NUM_PE(4), .QUERY_LEN(QL),
    .DB_LEN_MAX(8), .MATCH(2), .MISMATCH(-1), .GAP(-1)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .query_seq(s_query), .db_len(s_len),
    .db_valid(s_db_valid), .db_ready(s_db_ready), .db_letter(s_letter),
    .packet_valid(s_pv), .packet_stripe(s_ps), .packet_col(s_pc), .packet_data(s_pd),
    .busy(s_busy), .done(s_done), .max_score(s_max), .max_row(s_row), .max_col(s_col)
  );

  int tests = 0;
  int fails = 0;

  int   db_arr [32];
  pkt_t exp_q [$];
  int   exp_max, exp_row, exp_col;

  int          r_done_cyc, r_pkt_err, r_pkt_cnt;
  logic [11:0] r_first_data;
  bit          ab_ok;

  // Full score matrix from the recurrence, then packets/max in stripe, column, row order.
  task automatic model(input logic [15:0] q, input int n, input int sw);
    int hm [0:7][0:31];
    int sm [0:7][0:31];
    int maxv, d, t, l, b, s;
    pkt_t p;
    maxv = (1 << sw) - 1;
    exp_q.delete();
    exp_max = 0; exp_row = 0; exp_col = 0;
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < QL; i++) begin
        d = ((i > 0 && j > 0) ? hm[i-1][j-1] : 0) + ((int'(q[i*2 +: 2]) == db_arr[j]) ? 2 : -1);
        t = ((i > 0) ? hm[i-1][j] : 0) - 1;
        l = ((j > 0) ? hm[i][j-1] : 0) - 1;
        if (d >= t && d >= l) begin b = d; s = 1; end
        else if (t >= l)      begin b = t; s = 2; end
        else                  begin b = l; s = 3; end
        if (b <= 0) begin b = 0; s = 0; end
        else if (b > maxv) b = maxv;
        hm[i][j] = b;
        sm[i][j] = s;
      end
    end
    for (int st = 0; st < QL / 4; st++) begin
      for (int j = 0; j < n; j++) begin
        p.stripe = st; p.col = j; p.data = '0;
        for (int r = 0; r < 4; r++) begin
          p.data[r*3 +: 3] = {(hm[st*4+r][j] == 0), 2'(sm[st*4+r][j])};
          if (hm[st*4+r][j] > exp_max) begin
            exp_max = hm[st*4+r][j]; exp_row = st * 4 + r; exp_col = j;
          end
        end
        exp_q.push_back(p);
      end
    end
  endtask

  // Drives one job on u_dut and collects packets against the model scoreboard.
  task automatic run_job(input logic [15:0] q, input int len_port, input int n,
                         input int gap_after, input int gap_cyc,
                         input int mid_start, input int abort_at);
    int idx, cyc, gap_rem;
    bit hs;
    model(q, n, 10);
    r_done_cyc = -1; r_pkt_err = 0; r_pkt_cnt = 0; r_first_data = '0;
    idx = 0; cyc = 0; gap_rem = gap_cyc;
    @(posedge clk);
    @(negedge clk);
    query_seq = q; db_len = DBW'(len_port); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < 400) begin
      if (cyc == abort_at) begin
        db_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        ab_ok = (busy === 1'b0) && (done === 1'b0) && (packet_valid === 1'b0) &&
                (max_score === 10'd0) && (max_row === 3'd0) && (max_col === 5'd0) &&
                (db_ready === 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (packet_valid === 1'b1) begin
        if (r_pkt_cnt == 0) r_first_data = packet_data;
        r_pkt_cnt++;
`ifdef SW_TRACEBACK_EN
        if (exp_q.size() == 0) r_pkt_err++;
        else begin
          pkt_t e;
          e = exp_q.pop_front();
          if ({31'b0, packet_stripe} !== e.stripe || {27'b0, packet_col} !== e.col ||
              packet_data !== e.data)
            r_pkt_err++;
        end
`else
        r_pkt_err++;
`endif
      end
      if (done === 1'b1) begin
        r_done_cyc = cyc;
        break;
      end
      start = (cyc == mid_start);
      query_seq = start ? ~q : q;
      if (idx < n && !(idx == gap_after && gap_rem > 0)) begin
        db_valid = 1'b1;
        db_letter = 2'(db_arr[idx]);
      end else begin
        db_valid = 1'b0;
        if (idx < n && idx == gap_after) gap_rem--;
      end
      hs = db_valid && (db_ready === 1'b1);
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    start = 1'b0; db_valid = 1'b0; query_seq = q;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({busy, done, db_ready, packet_valid, max_score, max_row, max_col} !== '0) begin
      fails++;
      $display("FAIL reset_active: outputs=%h required 0",
               {busy, done, db_ready, packet_valid, max_score, max_row, max_col});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({busy, done, db_ready, packet_valid, max_score} !== '0 || s_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b done=%b ready=%b pv=%b max=%0d s_busy=%b required all 0",
               busy, done, db_ready, packet_valid, max_score, s_busy);
    end
  endtask

  task automatic check_job(input string name, input int exp_done, input logic [11:0] exp_first,
                           input bit check_first);
    tests++;
    if (r_done_cyc != exp_done) begin
      fails++;
      $display("FAIL %s_done: done at cycle %0d required %0d", name, r_done_cyc, exp_done);
    end
    tests++;
    if (max_score !== 10'(exp_max) || max_row !== 3'(exp_row) || max_col !== 5'(exp_col)) begin
      fails++;
      $display("FAIL %s_max: got %0d at (%0d,%0d) required %0d at (%0d,%0d)", name,
               max_score, max_row, max_col, exp_max, exp_row, exp_col);
    end
    tests++;
    if (r_pkt_err != 0 || r_pkt_cnt != (TB_TRACE ? 2 * (r_done_cyc > 0 ? exp_q.size() + r_pkt_cnt : 0) / 2 : 0)) begin
      fails++;
      $display("FAIL %s_packets: %0d bad, %0d seen, %0d left unseen, required 0 bad", name,
               r_pkt_err, r_pkt_cnt, exp_q.size());
    end
    if (check_first) begin
      tests++;
      if (r_first_data !== exp_first) begin
        fails++;
        $display("FAIL %s_first_pkt: data=%h required %h", name, r_first_data, exp_first);
      end
    end
  endtask

  task automatic test_identical();
    for (int k = 0; k < 4; k++) db_arr[k] = 0;
    run_job(16'h0000, 4, 4, -1, 0, -1, -1);
    check_job("identical", 8, TB_TRACE ? 12'h249 : 12'h000, 1'b1);
    tests++;
    if (exp_max != 8 || exp_row != 3 || exp_col != 3 || max_score !== 10'd8) begin
      fails++;
      $display("FAIL identical_const: got %0d at (%0d,%0d) required 8 at (3,3)",
               max_score, max_row, max_col);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (max_score !== 10'd8 || max_row !== 3'd3 || max_col !== 5'd3 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL identical_hold: max=%0d (%0d,%0d) busy=%b done=%b required 8 (3,3) 0 0",
               max_score, max_row, max_col, busy, done);
    end
  endtask

  task automatic test_back_to_back_gap();
    for (int k = 0; k < 4; k++) db_arr[k] = 0;
    run_job(16'h0000, 4, 4, 2, 3, -1, -1);
    check_job("backpressure", 11, TB_TRACE ? 12'h249 : 12'h000, 1'b1);
  endtask

  task automatic test_start_ignored();
    for (int k = 0; k < 6; k++) db_arr[k] = k % 4;
    run_job(16'h1b4e, 6, 6, -1, 0, 7, -1);
    check_job("start_ignored", 12, 12'h000, 1'b0);
  endtask

  task automatic test_mismatch();
    for (int k = 0; k < 4; k++) db_arr[k] = 1;
    run_job(16'h0000, 4, 4, -1, 0, -1, -1);
    check_job("mismatch", 8, TB_TRACE ? 12'h924 : 12'h000, 1'b1);
    tests++;
    if (max_score !== 10'd0 || max_row !== 3'd0 || max_col !== 5'd0) begin
      fails++;
      $display("FAIL mismatch_const: got %0d at (%0d,%0d) required 0 at (0,0)",
               max_score, max_row, max_col);
    end
  endtask

  task automatic test_empty();
    run_job(16'hffff, 0, 0, -1, 0, -1, -1);
    tests++;
    if (r_done_cyc != 0 || r_pkt_cnt != 0 || max_score !== 10'd0) begin
      fails++;
      $display("FAIL empty: done at %0d pkts=%0d max=%0d required 0 0 0",
               r_done_cyc, r_pkt_cnt, max_score);
    end
  endtask

  task automatic test_clamp();
    for (int k = 0; k < 16; k++) db_arr[k] = int'($urandom_range(0, 3));
    run_job(16'(($urandom)), 20, 16, -1, 0, -1, -1);
    check_job("clamp", 32, 12'h000, 1'b0);
  endtask

  task automatic test_random();
    int n, ga, gc;
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(1, 16));
      ga = int'($urandom_range(1, 4));
      gc = int'($urandom_range(0, 3));
      for (int k = 0; k < n; k++) db_arr[k] = int'($urandom_range(0, 3));
      run_job(16'($urandom), n, n, ga, gc, -1, -1);
      check_job("random", 2 * n + ((ga < n) ? gc : 0), 12'h000, 1'b0);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int k = 0; k < 4; k++) db_arr[k] = 0;
    ab_ok = 1'b0;
    run_job(16'h0000, 4, 4, -1, 0, -1, 6);
    tests++;
    if (!ab_ok) begin
      fails++;
      $display("FAIL reset_mid_run: busy=%b done=%b pv=%b max=%0d required all 0",
               busy, done, packet_valid, max_score);
    end
    run_job(16'h0000, 4, 4, -1, 0, -1, -1);
    check_job("after_reset", 8, TB_TRACE ? 12'h249 : 12'h000, 1'b1);
  endtask

  task automatic test_saturation();
    int k, cyc;
    bit hs;
    k = 0; cyc = 0;
    @(negedge clk);
    s_start = 1'b1; s_len = 4'd8; s_query = 16'h0000;
    @(posedge clk); #1;
    s_start = 1'b0;
    while (cyc < 200 && s_done !== 1'b1) begin
      s_db_valid = (k < 8);
      s_letter = 2'd0;
      hs = s_db_valid && (s_db_ready === 1'b1);
      @(posedge clk); #1;
      if (hs) k++;
      cyc++;
    end
    s_db_valid = 1'b0;
    tests++;
    if (s_done !== 1'b1 || cyc != 16) begin
      fails++;
      $display("FAIL saturation_done: done=%b at cycle %0d required 1 at 16", s_done, cyc);
    end
    tests++;
    if (s_max !== 4'd15 || s_row !== 3'd7 || s_col !== 4'd7) begin
      fails++;
      $display("FAIL saturation_max: got %0d at (%0d,%0d) required 15 at (7,7)",
               s_max, s_row, s_col);
    end
  endtask

  initial begin
    test_reset();
    test_identical();
    test_back_to_back_gap();
    test_start_ignored();
    test_mismatch();
    test_empty();
    test_clamp();
    test_random();
    test_reset_mid_run();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
